// File: rtl/alu_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : alu_exec_ctrl
// Description : Multi-cycle sequencer: register-file operand fetch, ALU
//               execute, 8/16-bit writeback and processor flags register.
// Revision    : 1.0 - initial release
// ============================================================================
module alu_exec_ctrl #(
    parameter int WIDTH       = 8,
    parameter int IDX_WIDTH   = 4,
    parameter int OPER_WIDTH  = 5,
    parameter int FLAGS_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start,
    input  logic [OPER_WIDTH-1:0]  op,
    input  logic                   op_is_pair,
    input  logic                   op_no_wb,
    input  logic [IDX_WIDTH-1:0]   ra_idx,
    input  logic [IDX_WIDTH-1:0]   rb_idx,
    input  logic [IDX_WIDTH-1:0]   rd_idx,
    input  logic                   flags_wr,
    input  logic [FLAGS_WIDTH-1:0] flags_wr_data,
    output logic                   busy,
    output logic                   done,
    output logic [FLAGS_WIDTH-1:0] flags_out,
    output logic [IDX_WIDTH-1:0]   rf_rd_a_idx,
    output logic [IDX_WIDTH-1:0]   rf_rd_b_idx,
    input  logic [WIDTH-1:0]       rf_rd_a_data,
    input  logic [WIDTH-1:0]       rf_rd_b_data,
    output logic                   rf_we,
    output logic [IDX_WIDTH-1:0]   rf_wr_idx,
    output logic [WIDTH-1:0]       rf_wr_data,
    output logic [OPER_WIDTH-1:0]  alu_oper,
    output logic [WIDTH-1:0]       alu_a_in_lo,
    output logic [WIDTH-1:0]       alu_a_in_hi,
    output logic [WIDTH-1:0]       alu_b_in,
    output logic [FLAGS_WIDTH-1:0] alu_proc_flags_in,
    input  logic [WIDTH-1:0]       alu_out_lo,
    input  logic [WIDTH-1:0]       alu_out_hi,
    input  logic [FLAGS_WIDTH-1:0] alu_proc_flags_out
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_RD0   = 3'd1;
    localparam logic [2:0] c_RD1   = 3'd2;
    localparam logic [2:0] c_RD2   = 3'd3;
    localparam logic [2:0] c_EX    = 3'd4;
    localparam logic [2:0] c_WB_LO = 3'd5;
    localparam logic [2:0] c_WB_HI = 3'd6;
    localparam logic [2:0] c_DONE  = 3'd7;

    localparam logic [IDX_WIDTH-1:0] c_IDX_ONE = IDX_WIDTH'(1);

    logic [2:0]             r_state_q,      w_state_d;
    logic [OPER_WIDTH-1:0]  r_oper_q,       w_oper_d;
    logic                   r_pair_q,       w_pair_d;
    logic                   r_no_wb_q,      w_no_wb_d;
    logic [IDX_WIDTH-1:0]   r_ra_q,         w_ra_d;
    logic [IDX_WIDTH-1:0]   r_rb_q,         w_rb_d;
    logic [IDX_WIDTH-1:0]   r_rd_q,         w_rd_d;
    logic [WIDTH-1:0]       r_a_lo_q,       w_a_lo_d;
    logic [WIDTH-1:0]       r_a_hi_q,       w_a_hi_d;
    logic [WIDTH-1:0]       r_b_q,          w_b_d;
    logic [WIDTH-1:0]       r_res_lo_q,     w_res_lo_d;
    logic [WIDTH-1:0]       r_res_hi_q,     w_res_hi_d;
    logic [FLAGS_WIDTH-1:0] r_flags_q,      w_flags_d;
    logic                   r_busy_q,       w_busy_d;
    logic                   r_done_q,       w_done_d;
    logic                   r_rf_we_q,      w_rf_we_d;
    logic [IDX_WIDTH-1:0]   r_rf_wr_idx_q,  w_rf_wr_idx_d;
    logic [WIDTH-1:0]       r_rf_wr_data_q, w_rf_wr_data_d;

    always_comb begin
        w_state_d  = r_state_q;
        w_oper_d   = r_oper_q;
        w_pair_d   = r_pair_q;
        w_no_wb_d  = r_no_wb_q;
        w_ra_d     = r_ra_q;
        w_rb_d     = r_rb_q;
        w_rd_d     = r_rd_q;
        w_a_lo_d   = r_a_lo_q;
        w_a_hi_d   = r_a_hi_q;
        w_b_d      = r_b_q;
        w_res_lo_d = r_res_lo_q;
        w_res_hi_d = r_res_hi_q;
        w_flags_d  = r_flags_q;

        case (r_state_q)
            c_IDLE: begin
                // Flag load lands first so a same-cycle op sees the new flags.
                if (flags_wr) w_flags_d = flags_wr_data;
                if (start) begin
                    w_oper_d  = op;
                    w_pair_d  = op_is_pair;
                    w_no_wb_d = op_no_wb;
                    w_ra_d    = ra_idx;
                    w_rb_d    = rb_idx;
                    w_rd_d    = rd_idx;
                    w_a_hi_d  = '0;
                    w_state_d = c_RD0;
                end
            end
            c_RD0: w_state_d = c_RD1;
            c_RD1: begin
                w_a_lo_d  = rf_rd_a_data;
                w_b_d     = rf_rd_b_data;
                w_state_d = r_pair_q ? c_RD2 : c_EX;
            end
            c_RD2: begin
                w_a_hi_d  = rf_rd_a_data;
                w_state_d = c_EX;
            end
            c_EX: begin
                w_res_lo_d = alu_out_lo;
                w_res_hi_d = alu_out_hi;
                w_flags_d  = alu_proc_flags_out;
                w_state_d  = r_no_wb_q ? c_DONE : c_WB_LO;
            end
            c_WB_LO: w_state_d = r_pair_q ? c_WB_HI : c_DONE;
            c_WB_HI: w_state_d = c_DONE;
            c_DONE:  w_state_d = c_IDLE;
            default: w_state_d = c_IDLE;
        endcase

        // Status and write-port outputs are registered from the next state so
        // rf_we comes straight off a flop and cannot glitch.
        w_busy_d       = (w_state_d != c_IDLE);
        w_done_d       = (w_state_d == c_DONE);
        w_rf_we_d      = (w_state_d == c_WB_LO) || (w_state_d == c_WB_HI);
        w_rf_wr_idx_d  = (w_state_d == c_WB_HI) ? (w_rd_d + c_IDX_ONE) : w_rd_d;
        w_rf_wr_data_d = (w_state_d == c_WB_HI) ? w_res_hi_d : w_res_lo_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state_q      <= c_IDLE;
            r_oper_q       <= '0;
            r_pair_q       <= 1'b0;
            r_no_wb_q      <= 1'b0;
            r_ra_q         <= '0;
            r_rb_q         <= '0;
            r_rd_q         <= '0;
            r_a_lo_q       <= '0;
            r_a_hi_q       <= '0;
            r_b_q          <= '0;
            r_res_lo_q     <= '0;
            r_res_hi_q     <= '0;
            r_flags_q      <= '0;
            r_busy_q       <= 1'b0;
            r_done_q       <= 1'b0;
            r_rf_we_q      <= 1'b0;
            r_rf_wr_idx_q  <= '0;
            r_rf_wr_data_q <= '0;
        end else begin
            r_state_q      <= w_state_d;
            r_oper_q       <= w_oper_d;
            r_pair_q       <= w_pair_d;
            r_no_wb_q      <= w_no_wb_d;
            r_ra_q         <= w_ra_d;
            r_rb_q         <= w_rb_d;
            r_rd_q         <= w_rd_d;
            r_a_lo_q       <= w_a_lo_d;
            r_a_hi_q       <= w_a_hi_d;
            r_b_q          <= w_b_d;
            r_res_lo_q     <= w_res_lo_d;
            r_res_hi_q     <= w_res_hi_d;
            r_flags_q      <= w_flags_d;
            r_busy_q       <= w_busy_d;
            r_done_q       <= w_done_d;
            r_rf_we_q      <= w_rf_we_d;
            r_rf_wr_idx_q  <= w_rf_wr_idx_d;
            r_rf_wr_data_q <= w_rf_wr_data_d;
        end
    end

    // RD1 fetches the pair's high half; the index wraps r15 -> r0.
    assign rf_rd_a_idx       = (r_state_q == c_RD1) ? (r_ra_q + c_IDX_ONE) : r_ra_q;
    assign rf_rd_b_idx       = r_rb_q;
    assign busy              = r_busy_q;
    assign done              = r_done_q;
    assign flags_out         = r_flags_q;
    assign rf_we             = r_rf_we_q;
    assign rf_wr_idx         = r_rf_wr_idx_q;
    assign rf_wr_data        = r_rf_wr_data_q;
    assign alu_oper          = r_oper_q;
    assign alu_a_in_lo       = r_a_lo_q;
    assign alu_a_in_hi       = r_a_hi_q;
    assign alu_b_in          = r_b_q;
    assign alu_proc_flags_in = r_flags_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_exec_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_exec_ctrl
// Description : Directed self-checking bench for alu_exec_ctrl with a small
//               register file and ALU attached.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_exec_ctrl;

    localparam logic [4:0] c_OP_ADD  = 5'd0;
    localparam logic [4:0] c_OP_ADC  = 5'd1;
    localparam logic [4:0] c_OP_CMP  = 5'd2;
    localparam logic [4:0] c_OP_LSLP = 5'd3;
    localparam int c_F_C = 0;
    localparam int c_F_Z = 1;
    localparam int c_F_N = 2;
    localparam int c_F_V = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic [4:0] op = '0;
    logic       op_is_pair = 1'b0;
    logic       op_no_wb = 1'b0;
    logic [3:0] ra_idx = '0;
    logic [3:0] rb_idx = '0;
    logic [3:0] rd_idx = '0;
    logic       flags_wr = 1'b0;
    logic [3:0] flags_wr_data = '0;
    logic       busy, done, rf_we;
    logic [3:0] flags_out, rf_rd_a_idx, rf_rd_b_idx, rf_wr_idx;
    logic [7:0] rf_rd_a_data, rf_rd_b_data, rf_wr_data;
    logic [4:0] alu_oper;
    logic [7:0] alu_a_in_lo, alu_a_in_hi, alu_b_in, alu_out_lo, alu_out_hi;
    logic [3:0] alu_proc_flags_in, alu_proc_flags_out;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    alu_exec_ctrl #(.WIDTH(8), .IDX_WIDTH(4), .OPER_WIDTH(5), .FLAGS_WIDTH(4)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op),
        .op_is_pair(op_is_pair), .op_no_wb(op_no_wb),
        .ra_idx(ra_idx), .rb_idx(rb_idx), .rd_idx(rd_idx),
        .flags_wr(flags_wr), .flags_wr_data(flags_wr_data),
        .busy(busy), .done(done), .flags_out(flags_out),
        .rf_rd_a_idx(rf_rd_a_idx), .rf_rd_b_idx(rf_rd_b_idx),
        .rf_rd_a_data(rf_rd_a_data), .rf_rd_b_data(rf_rd_b_data),
        .rf_we(rf_we), .rf_wr_idx(rf_wr_idx), .rf_wr_data(rf_wr_data),
        .alu_oper(alu_oper), .alu_a_in_lo(alu_a_in_lo), .alu_a_in_hi(alu_a_in_hi),
        .alu_b_in(alu_b_in), .alu_proc_flags_in(alu_proc_flags_in),
        .alu_out_lo(alu_out_lo), .alu_out_hi(alu_out_hi),
        .alu_proc_flags_out(alu_proc_flags_out)
    );

    // Synchronous register file with a bench-side preload port and write log.
    logic [7:0] rf [16];
    logic       pre_we = 1'b0;
    logic [3:0] pre_idx = '0;
    logic [7:0] pre_data = '0;
    int         wr_cnt = 0;
    logic [3:0] wr_idx_log  [64];
    logic [7:0] wr_data_log [64];

    always @(posedge clk) begin
        rf_rd_a_data <= rf[rf_rd_a_idx];
        rf_rd_b_data <= rf[rf_rd_b_idx];
        if (rf_we) begin
            rf[rf_wr_idx]                <= rf_wr_data;
            wr_idx_log[wr_cnt % 64]      <= rf_wr_idx;
            wr_data_log[wr_cnt % 64]     <= rf_wr_data;
            wr_cnt                       <= wr_cnt + 1;
        end else if (pre_we) begin
            rf[pre_idx] <= pre_data;
        end
    end

    // Reference ALU for the four opcodes exercised here.
    logic [8:0]  t9;
    logic [16:0] t17;
    always_comb begin
        t9 = '0;
        t17 = '0;
        alu_out_lo = '0;
        alu_out_hi = '0;
        alu_proc_flags_out = '0;
        case (alu_oper)
            c_OP_ADD, c_OP_ADC: begin
                t9 = {1'b0, alu_a_in_lo} + {1'b0, alu_b_in}
                   + {8'd0, (alu_oper == c_OP_ADC) ? alu_proc_flags_in[c_F_C] : 1'b0};
                alu_out_lo = t9[7:0];
                alu_proc_flags_out[c_F_C] = t9[8];
                alu_proc_flags_out[c_F_Z] = (t9[7:0] == 8'd0);
                alu_proc_flags_out[c_F_N] = t9[7];
                alu_proc_flags_out[c_F_V] = (alu_a_in_lo[7] == alu_b_in[7]) && (t9[7] != alu_a_in_lo[7]);
            end
            c_OP_CMP: begin
                t9 = {1'b0, alu_a_in_lo} - {1'b0, alu_b_in};
                alu_out_lo = t9[7:0];
                alu_proc_flags_out[c_F_C] = t9[8];
                alu_proc_flags_out[c_F_Z] = (t9[7:0] == 8'd0);
                alu_proc_flags_out[c_F_N] = t9[7];
                alu_proc_flags_out[c_F_V] = (alu_a_in_lo[7] != alu_b_in[7]) && (t9[7] != alu_a_in_lo[7]);
            end
            c_OP_LSLP: begin
                t17 = {1'b0, alu_a_in_hi, alu_a_in_lo} << alu_b_in[3:0];
                alu_out_lo = t17[7:0];
                alu_out_hi = t17[15:8];
                alu_proc_flags_out[c_F_C] = t17[16];
                alu_proc_flags_out[c_F_Z] = (t17[15:0] == 16'd0);
                alu_proc_flags_out[c_F_N] = t17[15];
            end
            default: ;
        endcase
    end

    task automatic set_reg(input logic [3:0] i, input logic [7:0] d);
        @(posedge clk); #1;
        pre_we = 1'b1; pre_idx = i; pre_data = d;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    // Returns one cycle after the accepting edge (cycle 1, state RD0).
    task automatic start_op(input logic [4:0] o, input logic pair, input logic nowb,
                            input logic [3:0] a, input logic [3:0] b, input logic [3:0] d);
        @(posedge clk); #1;
        op = o; op_is_pair = pair; op_no_wb = nowb;
        ra_idx = a; rb_idx = b; rd_idx = d; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int c0, output int cyc);
        cyc = c0;
        while (done !== 1'b1 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        n_checks++;
        if ({busy, done, rf_we} !== 3'b000) begin
            n_fail++; $display("FAIL reset_ctrl: busy/done/we=%b expected 000", {busy, done, rf_we});
        end
        n_checks++;
        if (flags_out !== 4'h0 || alu_a_in_lo !== 8'h0 || alu_oper !== 5'h0) begin
            n_fail++; $display("FAIL reset_regs: flags=%h a_lo=%h oper=%h expected 0", flags_out, alu_a_in_lo, alu_oper);
        end
    endtask

    task automatic test_add();
        int cyc, w0;
        set_reg(4'd1, 8'h7F); set_reg(4'd2, 8'h01); set_reg(4'd3, 8'h00);
        w0 = wr_cnt;
        start_op(c_OP_ADD, 1'b0, 1'b0, 4'd1, 4'd2, 4'd3);
        wait_done(1, cyc);
        n_checks++;
        if (cyc !== 5) begin n_fail++; $display("FAIL add_latency: got %0d expected 5", cyc); end
        n_checks++;
        if (wr_cnt - w0 !== 1 || wr_idx_log[w0] !== 4'd3 || wr_data_log[w0] !== 8'h80) begin
            n_fail++; $display("FAIL add_write: cnt=%0d idx=%0d data=%h expected 1/3/80", wr_cnt - w0, wr_idx_log[w0], wr_data_log[w0]);
        end
        n_checks++;
        if (flags_out !== 4'b1100) begin n_fail++; $display("FAIL add_flags: got %b expected 1100", flags_out); end
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL add_idle: busy=%b done=%b expected 0 0", busy, done); end
    endtask

    task automatic test_cmp();
        int cyc, w0;
        set_reg(4'd1, 8'h05); set_reg(4'd2, 8'h05);
        w0 = wr_cnt;
        start_op(c_OP_CMP, 1'b0, 1'b1, 4'd1, 4'd2, 4'd4);
        wait_done(1, cyc);
        n_checks++;
        if (cyc !== 4) begin n_fail++; $display("FAIL cmp_latency: got %0d expected 4", cyc); end
        n_checks++;
        if (wr_cnt !== w0) begin n_fail++; $display("FAIL cmp_nowb: writes=%0d expected 0", wr_cnt - w0); end
        n_checks++;
        if (flags_out !== 4'b0010) begin n_fail++; $display("FAIL cmp_flags: got %b expected 0010", flags_out); end
    endtask

    task automatic test_lslp_wrap();
        int cyc, w0;
        set_reg(4'd15, 8'h01); set_reg(4'd0, 8'h80); set_reg(4'd2, 8'h01);
        w0 = wr_cnt;
        start_op(c_OP_LSLP, 1'b1, 1'b0, 4'd15, 4'd2, 4'd15);
        wait_done(1, cyc);
        n_checks++;
        if (cyc !== 7) begin n_fail++; $display("FAIL lslp_latency: got %0d expected 7", cyc); end
        n_checks++;
        if (alu_a_in_lo !== 8'h01 || alu_a_in_hi !== 8'h80) begin
            n_fail++; $display("FAIL lslp_reads: a_lo=%h a_hi=%h expected 01 80", alu_a_in_lo, alu_a_in_hi);
        end
        n_checks++;
        if (wr_cnt - w0 !== 2 || wr_idx_log[w0] !== 4'd15 || wr_data_log[w0] !== 8'h02
            || wr_idx_log[w0 + 1] !== 4'd0 || wr_data_log[w0 + 1] !== 8'h00) begin
            n_fail++; $display("FAIL lslp_writes: cnt=%0d w0=%0d:%h w1=%0d:%h expected 2 15:02 0:00",
                wr_cnt - w0, wr_idx_log[w0], wr_data_log[w0], wr_idx_log[w0 + 1], wr_data_log[w0 + 1]);
        end
        n_checks++;
        if (flags_out !== 4'b0001) begin n_fail++; $display("FAIL lslp_flags: got %b expected 0001", flags_out); end
    endtask

    task automatic test_flags_wr_start();
        int cyc;
        set_reg(4'd4, 8'h00); set_reg(4'd5, 8'h00); set_reg(4'd6, 8'hAA);
        @(posedge clk); #1;
        op = c_OP_ADC; op_is_pair = 1'b0; op_no_wb = 1'b0;
        ra_idx = 4'd4; rb_idx = 4'd5; rd_idx = 4'd6; start = 1'b1;
        flags_wr = 1'b1; flags_wr_data = 4'b0001;
        @(posedge clk); #1;
        start = 1'b0;
        flags_wr_data = 4'hF;
        wait_done(1, cyc);
        flags_wr = 1'b0;
        n_checks++;
        if (cyc !== 5) begin n_fail++; $display("FAIL adc_latency: got %0d expected 5", cyc); end
        n_checks++;
        if (rf[6] !== 8'h01) begin n_fail++; $display("FAIL adc_result: got %h expected 01", rf[6]); end
        n_checks++;
        if (flags_out !== 4'b0000) begin n_fail++; $display("FAIL adc_flags: got %b expected 0000", flags_out); end
    endtask

    task automatic test_back_to_back();
        int cyc, w0;
        set_reg(4'd1, 8'h7F);
        w0 = wr_cnt;
        @(posedge clk); #1;
        op = c_OP_ADD; op_is_pair = 1'b0; op_no_wb = 1'b0;
        ra_idx = 4'd1; rb_idx = 4'd2; rd_idx = 4'd7; start = 1'b1;
        @(posedge clk); #1;
        repeat (3) begin @(posedge clk); #1; end
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin n_fail++; $display("FAIL b2b_cycle4: busy=%b done=%b expected 1 0", busy, done); end
        @(posedge clk); #1;
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_done5: done=%b expected 1", done); end
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL b2b_idle6: busy=%b expected 0", busy); end
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_accept7: busy=%b expected 1", busy); end
        start = 1'b0;
        wait_done(1, cyc);
        n_checks++;
        if (cyc !== 5 || wr_cnt - w0 !== 2) begin
            n_fail++; $display("FAIL b2b_second: latency=%0d writes=%0d expected 5 2", cyc, wr_cnt - w0);
        end
    endtask

    task automatic test_start_during_rd1();
        int cyc, w0;
        w0 = wr_cnt;
        start_op(c_OP_ADD, 1'b0, 1'b0, 4'd1, 4'd2, 4'd8);
        @(posedge clk); #1;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        wait_done(3, cyc);
        n_checks++;
        if (cyc !== 5) begin n_fail++; $display("FAIL rd1_latency: got %0d expected 5", cyc); end
        @(posedge clk); #1;
        @(posedge clk); #1;
        n_checks++;
        if (busy !== 1'b0 || wr_cnt - w0 !== 1) begin
            n_fail++; $display("FAIL rd1_dropped: busy=%b writes=%0d expected 0 1", busy, wr_cnt - w0);
        end
    endtask

    task automatic test_reset_midop();
        int w0;
        @(posedge clk); #1;
        flags_wr = 1'b1; flags_wr_data = 4'hF;
        @(posedge clk); #1;
        flags_wr = 1'b0;
        n_checks++;
        if (flags_out !== 4'hF) begin n_fail++; $display("FAIL flags_load: got %h expected f", flags_out); end
        w0 = wr_cnt;
        start_op(c_OP_LSLP, 1'b1, 1'b0, 4'd15, 4'd2, 4'd9);
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0 || flags_out !== 4'h0) begin
            n_fail++; $display("FAIL midop_reset: busy=%b done=%b flags=%h expected 0 0 0", busy, done, flags_out);
        end
        repeat (8) @(posedge clk);
        #1;
        n_checks++;
        if (wr_cnt !== w0 || busy !== 1'b0) begin
            n_fail++; $display("FAIL midop_nowrite: writes=%0d busy=%b expected 0 0", wr_cnt - w0, busy);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_add();
        test_cmp();
        test_lslp_wrap();
        test_flags_wr_start();
        test_back_to_back();
        test_start_during_rd1();
        test_reset_midop();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
